axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Shares the core's single AXI4 read port (AR/R channels of `m_axi_*`) between `NUM_REQ` internal requesters: requester 0 is instruction fetch, requester 1 is data load.
- Accepts one burst request at a time and issues it on AR.
- Routes every R beat back to the owning requester.
- Checks beat count against the requested length.
- Sits between the fetch/load stages and the top-level bus ports; AW/W/B channels are untouched.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; index 0 has first grant after reset.
- `ID_WIDTH`, 13: AXI ID width.
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 64: read data width.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `req_valid`  in  [NUM_REQ]  requester has a burst request.
- `req_ready`  out  [NUM_REQ]  request accepted this cycle (one-hot or zero).
- `req_addr`  in  [NUM_REQ][ADDR_WIDTH]  burst start address.
- `req_len`  in  [NUM_REQ][8]  AXI len (beats − 1).
- `req_size`  in  [NUM_REQ][3]  AXI size.
- `req_burst`  in  [NUM_REQ][2]  AXI burst type.
- `rsp_valid`  out  [NUM_REQ]  R beat for this requester.
- `rsp_ready`  in  [NUM_REQ]  requester accepts the beat.
- `rsp_data`  out  DATA_WIDTH  beat data, shared by all requesters.
- `rsp_resp`  out  2  beat response, shared.
- `rsp_last`  out  1  final beat, shared.
- `m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid`  out  AXI AR channel.
- `m_axi_arready`  in  1.
- `m_axi_rid/rdata/rresp/rlast/rvalid`  in  AXI R channel.
- `m_axi_rready`  out  1.
- `busy`  out  1  a transaction is in flight (state ≠ IDLE).
- `owner`  out  $clog2(NUM_REQ)  current or last grantee.
- `proto_err`  out  1  sticky: beat-count mismatch seen.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `req_valid` is high, pick a winner by round-robin, starting from `last_grant+1`.
  - Assert `req_ready[winner]` combinationally that cycle.
  - Latch addr/len/size/burst into AR registers, set `owner`, go to ADDR.
- ADDR:
  - `m_axi_arvalid`=1, fields from registers; `arid`=owner zero-extended.
  - `arlock`=0, `arcache`=4'b0011, `arprot`=3'b000.
  - On `arready`, go to DATA and clear the beat counter.
- DATA:
  - `m_axi_rready`=`rsp_ready[owner]`.
  - `rsp_valid[owner]`=`m_axi_rvalid`; other requesters' `rsp_valid`=0.
  - data/resp/last pass through combinationally.
  - Each beat handshake increments the 8-bit counter.
  - On the handshake with `rlast`=1: update `last_grant`=owner and go to IDLE.
- Beat check:
  - `rlast` on a beat with counter ≠ latched len sets `proto_err`.
  - A beat with counter = len and `rlast`=0 also sets `proto_err`.
  - Only `rlast` ends the transaction.
- `rid` is not used for routing, because only one transaction is ever outstanding. `rid` ≠ owner sets `proto_err`.
- `rresp` is forwarded unchanged; it does not set the error.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=NUM_REQ−1, `owner`=0.
  - `m_axi_arvalid`=0, `m_axi_rready`=0, `req_ready`=0, `rsp_valid`=0.
  - AR fields 0, `busy`=0, `proto_err`=0, beat counter 0.
- Request accepted at cycle T (IDLE) → `arvalid` high at T+1, held stable until `arready`.
- R path is zero-latency combinational; no R buffering.
- Last beat handshake at cycle T → IDLE at T+1 → next grant possible at T+1, `arvalid` at T+2.
- `req_ready` is only asserted in IDLE. A requester holds `req_valid` and fields until accepted; deasserting earlier is legal, and the request is then not seen.
- Simultaneous requests in IDLE: exactly one grant. After reset requester 0 wins; the next contested grant goes to requester 1.
- R beats arriving in IDLE/ADDR: `m_axi_rready`=0; not consumed.
- Reset asserted mid-burst: immediate return to reset values. Outstanding beats are abandoned, on the basis that the whole bus is reset together.

## Structure
- Shared package `arb_pkg`:
  - state enum `arb_state_t`
  - `ARCACHE_DEFAULT`, `ARPROT_DEFAULT` constants
  - requester index constants `REQ_IFETCH`=0, `REQ_DMEM`=1
- Sub-module `rr_picker`: combinational round-robin priority over `req_valid` given `last_grant`; outputs a one-hot grant and its index.

## Test plan
- Single fetch: `req_valid[0]`, addr 0x1000, len 7, size 3'b010, burst 2'b10 → AR fields match, arid=0, 8 beats routed to requester 0, `busy` falls the cycle after the rlast beat.
- Contention: both requests valid in the same IDLE cycle, repeated 4 times → grant order 0,1,0,1, never two `req_ready` bits high together.
- Backpressure: `arready` low 5 cycles, `rsp_ready[1]` toggling on a 4-beat load → AR fields stable while `arvalid` high, exactly 4 beats delivered with no duplicates, `m_axi_rready` tracks `rsp_ready[1]`.
- Protocol error: len 3 but `rlast` on beat 2; separately, `rid`=1 while owner=0 → `proto_err` rises and stays high, FSM returns to IDLE on `rlast`.
- Reset mid-DATA: drop `reset` after 3 of 8 beats → all outputs at reset values immediately (asynchronous), first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the AXI read-port arbiter
package arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_t;

   localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] ARPROT_DEFAULT  = 3'b000;

   localparam int REQ_IFETCH = 0;
   localparam int REQ_DMEM   = 1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin pick over req_valid, starting one past last_grant
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   int         idx;
   logic [IDX_W-1:0] idx_v;

   // Walk the ring once; the first valid requester after last_grant wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      idx_v     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx   = (int'(last_grant) + i) % NUM_REQ;
         idx_v = IDX_W'(idx);
         if (!any && req_valid[idx_v]) begin
            grant[idx_v] = 1'b1;
            grant_idx    = idx_v;
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one AXI4 read port among NUM_REQ requesters, one burst at a time
module axi_read_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][7:0]             req_len,
   input  logic [NUM_REQ-1:0][2:0]             req_size,
   input  logic [NUM_REQ-1:0][1:0]             req_burst,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   input  logic [NUM_REQ-1:0]                  rsp_ready,
   output logic [DATA_WIDTH-1:0]               rsp_data,
   output logic [1:0]                          rsp_resp,
   output logic                                rsp_last,
   output logic [ID_WIDTH-1:0]                 m_axi_arid,
   output logic [ADDR_WIDTH-1:0]               m_axi_araddr,
   output logic [7:0]                          m_axi_arlen,
   output logic [2:0]                          m_axi_arsize,
   output logic [1:0]                          m_axi_arburst,
   output logic                                m_axi_arlock,
   output logic [3:0]                          m_axi_arcache,
   output logic [2:0]                          m_axi_arprot,
   output logic                                m_axi_arvalid,
   input  logic                                m_axi_arready,
   input  logic [ID_WIDTH-1:0]                 m_axi_rid,
   input  logic [DATA_WIDTH-1:0]               m_axi_rdata,
   input  logic [1:0]                          m_axi_rresp,
   input  logic                                m_axi_rlast,
   input  logic                                m_axi_rvalid,
   output logic                                m_axi_rready,
   output logic                                busy,
   output logic [OW-1:0]                       owner,
   output logic                                proto_err
);

   arb_state_t          state;
   logic [OW-1:0]       last_grant;
   logic [7:0]          beat_cnt;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [OW-1:0]       pick_idx;
   logic                pick_any;
   logic                r_hs;
   logic                beat_err;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OW)
   ) u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .grant_idx  (pick_idx),
      .any        (pick_any)
   );

   assign req_ready     = (state == ST_IDLE && reset) ? pick_grant : '0;
   assign m_axi_arid    = ID_WIDTH'(owner);
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = ARCACHE_DEFAULT;
   assign m_axi_arprot  = ARPROT_DEFAULT;

   // R path is a pure pass-through; only the owner sees rvalid and drives rready.
   assign m_axi_rready = (state == ST_DATA) && rsp_ready[owner];
   assign rsp_data     = m_axi_rdata;
   assign rsp_resp     = m_axi_rresp;
   assign rsp_last     = m_axi_rlast;
   assign r_hs         = (state == ST_DATA) && m_axi_rvalid && m_axi_rready;

   always_comb begin
      rsp_valid = '0;
      if (state == ST_DATA)
         rsp_valid[owner] = m_axi_rvalid;
   end

   // rlast must coincide exactly with the beat whose count equals the latched len.
   assign beat_err = (m_axi_rlast != (beat_cnt == m_axi_arlen)) ||
                     (m_axi_rid != ID_WIDTH'(owner));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         last_grant    <= OW'(NUM_REQ - 1);
         owner         <= '0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arsize  <= '0;
         m_axi_arburst <= '0;
         m_axi_arvalid <= 1'b0;
         busy          <= 1'b0;
         proto_err     <= 1'b0;
         beat_cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  m_axi_araddr  <= req_addr[pick_idx];
                  m_axi_arlen   <= req_len[pick_idx];
                  m_axi_arsize  <= req_size[pick_idx];
                  m_axi_arburst <= req_burst[pick_idx];
                  owner         <= pick_idx;
                  m_axi_arvalid <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_err)
                     proto_err <= 1'b1;
                  if (m_axi_rlast) begin
                     last_grant <= owner;
                     busy       <= 1'b0;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - scoreboard bench for axi_read_arbiter
module tb_axi_read_arbiter;
   import arb_pkg::*;

   localparam int NR  = 2;
   localparam int IDW = 13;
   localparam int AW  = 64;
   localparam int DW  = 64;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [NR-1:0]            req_valid;
   logic [NR-1:0]            req_ready;
   logic [NR-1:0][AW-1:0]    req_addr;
   logic [NR-1:0][7:0]       req_len;
   logic [NR-1:0][2:0]       req_size;
   logic [NR-1:0][1:0]       req_burst;
   logic [NR-1:0]            rsp_valid;
   logic [NR-1:0]            rsp_ready;
   logic [DW-1:0]            rsp_data;
   logic [1:0]               rsp_resp;
   logic                     rsp_last;
   logic [IDW-1:0]           m_axi_arid;
   logic [AW-1:0]            m_axi_araddr;
   logic [7:0]               m_axi_arlen;
   logic [2:0]               m_axi_arsize;
   logic [1:0]               m_axi_arburst;
   logic                     m_axi_arlock;
   logic [3:0]               m_axi_arcache;
   logic [2:0]               m_axi_arprot;
   logic                     m_axi_arvalid;
   logic                     m_axi_arready;
   logic [IDW-1:0]           m_axi_rid;
   logic [DW-1:0]            m_axi_rdata;
   logic [1:0]               m_axi_rresp;
   logic                     m_axi_rlast;
   logic                     m_axi_rvalid;
   logic                     m_axi_rready;
   logic                     busy;
   logic [0:0]               owner;
   logic                     proto_err;

   always #5 clk = ~clk;

   axi_read_arbiter #(
      .NUM_REQ    (NR),
      .ID_WIDTH   (IDW),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .req_size      (req_size),
      .req_burst     (req_burst),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_resp      (rsp_resp),
      .rsp_last      (rsp_last),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .busy          (busy),
      .owner         (owner),
      .proto_err     (proto_err)
   );

   typedef struct {
      int          req;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e;
   int    n_checks = 0;
   int    n_errors = 0;
   int    exp_owner = 0;
   bit    in_data = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (req_ready != '0) check("req_ready_onehot", $countones(req_ready), 1);
         if (rsp_valid != '0) check("rsp_valid_onehot", $countones(rsp_valid), 1);
         if (in_data && m_axi_rvalid)
            check("rready_track", m_axi_rready, rsp_ready[exp_owner]);
         for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (exp_q.size() == 0) begin
                  check("sb_underflow", exp_q.size(), 1);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("beat_req", i, mon_e.req);
                  check("beat_data", rsp_data, mon_e.data);
                  check("beat_resp", rsp_resp, mon_e.resp);
                  check("beat_last", rsp_last, mon_e.last);
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0;
      m_axi_arready = 1'b0;
      in_data = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rready", m_axi_rready, 0);
      check("rst_araddr", m_axi_araddr, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int r, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      req_addr[r]  = addr;
      req_len[r]   = len;
      req_size[r]  = size;
      req_burst[r] = burst;
   endtask

   task automatic wait_grant(input int r);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (req_ready[r]) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("grant_seen", seen, 1);
      @(posedge clk); #1;
      req_valid = '0;
      check("owner", owner, r);
   endtask

   task automatic ar_phase(input int r, input int delay);
      for (int d = 0; d <= delay; d++) begin
         if (d == delay) m_axi_arready = 1'b1;
         @(negedge clk);
         check("arvalid", m_axi_arvalid, 1);
         check("araddr", m_axi_araddr, req_addr[r]);
         check("arlen", m_axi_arlen, req_len[r]);
         check("arsize", m_axi_arsize, req_size[r]);
         check("arburst", m_axi_arburst, req_burst[r]);
         check("arid", m_axi_arid, r);
         if (d == delay) begin
            check("arlock", m_axi_arlock, 0);
            check("arcache", m_axi_arcache, 4'b0011);
            check("arprot", m_axi_arprot, 0);
         end
         @(posedge clk); #1;
      end
      m_axi_arready = 1'b0;
   endtask

   task automatic r_phase(input int r, input int nbeats, input logic [IDW-1:0] rid, input bit toggle);
      logic [63:0] d;
      bit          hs;
      exp_owner = r;
      in_data = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
         d = {$urandom(), $urandom()};
         m_axi_rvalid = 1'b1;
         m_axi_rdata = d;
         m_axi_rresp = 2'(b);
         m_axi_rlast = (b == nbeats - 1);
         m_axi_rid = rid;
         exp_q.push_back('{req: r, data: d, resp: 2'(b), last: (b == nbeats - 1)});
         hs = 1'b0;
         for (int c = 0; c < 50 && !hs; c++) begin
            if (toggle) rsp_ready[r] = ~rsp_ready[r];
            @(negedge clk);
            hs = m_axi_rready;
            @(posedge clk); #1;
         end
         check("beat_handshake", hs, 1);
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0;
      in_data = 1'b0;
      rsp_ready = '1;
      @(negedge clk);
      check("busy_after_last", busy, 0);
      check("sb_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] d;
      req_valid = '0;
      req_addr = '0;
      req_len = '0;
      req_size = '0;
      req_burst = '0;
      rsp_ready = '1;
      m_axi_arready = 1'b0;
      m_axi_rid = '0;
      m_axi_rdata = '0;
      m_axi_rresp = '0;
      m_axi_rlast = 1'b0;
      m_axi_rvalid = 1'b0;
      #2;
      do_reset();

      // single fetch
      set_req(REQ_IFETCH, 64'h1000, 8'd7, 3'b010, 2'b10);
      req_valid[REQ_IFETCH] = 1'b1;
      wait_grant(REQ_IFETCH);
      ar_phase(REQ_IFETCH, 0);
      r_phase(REQ_IFETCH, 8, 0, 1'b0);

      // backpressure on a load
      set_req(REQ_DMEM, 64'h8040, 8'd3, 3'b011, 2'b01);
      req_valid[REQ_DMEM] = 1'b1;
      wait_grant(REQ_DMEM);
      ar_phase(REQ_DMEM, 5);
      rsp_ready[REQ_DMEM] = 1'b0;
      r_phase(REQ_DMEM, 4, 1, 1'b1);
      check("no_err_clean", proto_err, 0);

      // contention, four rounds
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(0, 64'h2000 + 64'(k) * 64'h100, 8'd0, 3'b011, 2'b01);
         set_req(1, 64'h3000 + 64'(k) * 64'h100, 8'd0, 3'b011, 2'b01);
         req_valid = 2'b11;
         @(negedge clk);
         check("contend_winner", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         @(posedge clk); #1;
         req_valid = '0;
         ar_phase(k % 2, 0);
         r_phase(k % 2, 1, IDW'(k % 2), 1'b0);
      end

      // early rlast
      do_reset();
      set_req(0, 64'h4000, 8'd3, 3'b011, 2'b01);
      req_valid[0] = 1'b1;
      wait_grant(0);
      ar_phase(0, 0);
      r_phase(0, 3, 0, 1'b0);
      check("perr_short", proto_err, 1);
      repeat (3) @(posedge clk);
      #1;
      check("perr_sticky", proto_err, 1);

      // wrong rid
      do_reset();
      set_req(0, 64'h5000, 8'd1, 3'b011, 2'b01);
      req_valid[0] = 1'b1;
      wait_grant(0);
      ar_phase(0, 0);
      r_phase(0, 2, 1, 1'b0);
      check("perr_rid", proto_err, 1);

      // reset mid-DATA
      do_reset();
      set_req(0, 64'h6000, 8'd7, 3'b011, 2'b01);
      req_valid[0] = 1'b1;
      wait_grant(0);
      ar_phase(0, 0);
      exp_owner = 0;
      in_data = 1'b1;
      for (int b = 0; b < 3; b++) begin
         d = {$urandom(), $urandom()};
         m_axi_rvalid = 1'b1;
         m_axi_rdata = d;
         m_axi_rresp = 2'b00;
         m_axi_rlast = 1'b0;
         m_axi_rid = '0;
         exp_q.push_back('{req: 0, data: d, resp: 2'b00, last: 1'b0});
         @(negedge clk);
         check("mid_rready", m_axi_rready, 1);
         @(posedge clk); #1;
      end
      m_axi_rdata = 64'hdead;
      #2;
      reset = 1'b0;
      in_data = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_arvalid", m_axi_arvalid, 0);
      check("async_rready", m_axi_rready, 0);
      check("async_rsp_valid", rsp_valid, 0);
      check("async_req_ready", req_ready, 0);
      check("async_owner", owner, 0);
      check("async_proto_err", proto_err, 0);
      check("async_araddr", m_axi_araddr, 0);
      check("async_arlen", m_axi_arlen, 0);
      check("mid_sb_empty", exp_q.size(), 0);
      m_axi_rvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      set_req(0, 64'h7000, 8'd0, 3'b011, 2'b01);
      set_req(1, 64'h7800, 8'd0, 3'b011, 2'b01);
      req_valid = 2'b11;
      @(negedge clk);
      check("post_reset_winner", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = '0;
      ar_phase(0, 0);
      r_phase(0, 1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
